// File: rtl/run_detector.sv
// run_detector: tracks the length of the current run of identical serial bits.
// Flags a run of RUN_LEN bits through a polarity filter, emits a one-cycle hit
// pulse per detection and keeps a saturating detection count.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous reset, active low
//   en         sample qualifier; w is consumed only when en=1
//   w          serial data bit
//   mode       00 either polarity, 01 ones only, 10 zeros only, 11 disabled
//   clr_cnt    synchronous clear of hit_count (wins over a simultaneous event)
//   z          detection flag, from state and the current mode
//   hit        registered one-cycle pulse per detection event
//   hit_count  saturating detection count
//   leds       live state {last_w, run_cnt}
module run_detector #(
    parameter int unsigned RUN_LEN = 4,
    parameter int unsigned OVERLAP = 1,
    parameter int unsigned CNT_W   = 8,
    localparam int unsigned RW     = $clog2(RUN_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             w,
    input  logic [1:0]       mode,
    input  logic             clr_cnt,
    output logic             z,
    output logic             hit,
    output logic [CNT_W-1:0] hit_count,
    output logic [RW:0]      leds
);

    localparam logic [RW-1:0]    RunMax = RW'(RUN_LEN);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [RW-1:0]    run_q, run_d;
    logic             last_q, last_d;
    logic             hit_q, hit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             event_hit;

    function automatic logic polarity_match(input logic [1:0] m, input logic b);
        logic r;
        case (m)
            2'b00:   r = 1'b1;
            2'b01:   r = b;
            2'b10:   r = ~b;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    always_comb begin
        run_d  = run_q;
        last_d = last_q;
        if (en) begin
            // run_cnt=0 has no valid last_w, so any bit starts a fresh run.
            if (run_q == '0 || w != last_q) begin
                run_d  = RW'(1);
                last_d = w;
            end else if (run_q < RunMax) begin
                run_d = run_q + RW'(1);
            end else if (OVERLAP == 0) begin
                run_d = RW'(1);
            end
        end
    end

    // The event is judged on the next state, so it is visible with the edge that
    // samples the RUN_LEN-th bit.
    assign event_hit = en && (run_d == RunMax) && polarity_match(mode, last_d);

    always_comb begin
        hit_d = event_hit;
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (event_hit && cnt_q != CntMax) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q  <= '0;
            last_q <= 1'b0;
            hit_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            run_q  <= run_d;
            last_q <= last_d;
            hit_q  <= hit_d;
            cnt_q  <= cnt_d;
        end
    end

    assign z         = (run_q == RunMax) && polarity_match(mode, last_q);
    assign hit       = hit_q;
    assign hit_count = cnt_q;
    assign leds      = {last_q, run_q};

endmodule

// File: tb/tb_run_detector.sv
module tb_run_detector;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       w = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       clr_cnt = 1'b0;

    // dut4: overlapping, 8-bit count; dutn: non-overlapping; dutc: 2-bit count
    logic       z4, zn, zc;
    logic       hit4, hitn, hitc;
    logic [7:0] hc4, hcn;
    logic [1:0] hcc;
    logic [3:0] leds4, ledsn, ledsc;

    int errors = 0;
    int checks = 0;
    int step_no = 0;

    typedef struct {
        int sel;
        int idx;
        bit eh;
        int ec;
        bit ez;
        int el;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    run_detector #(.RUN_LEN(4), .OVERLAP(1), .CNT_W(8)) dut4 (
        .clk(clk), .reset(reset), .en(en), .w(w), .mode(mode), .clr_cnt(clr_cnt),
        .z(z4), .hit(hit4), .hit_count(hc4), .leds(leds4)
    );

    run_detector #(.RUN_LEN(4), .OVERLAP(0), .CNT_W(8)) dutn (
        .clk(clk), .reset(reset), .en(en), .w(w), .mode(mode), .clr_cnt(clr_cnt),
        .z(zn), .hit(hitn), .hit_count(hcn), .leds(ledsn)
    );

    run_detector #(.RUN_LEN(4), .OVERLAP(1), .CNT_W(2)) dutc (
        .clk(clk), .reset(reset), .en(en), .w(w), .mode(mode), .clr_cnt(clr_cnt),
        .z(zc), .hit(hitc), .hit_count(hcc), .leds(ledsc)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one sample at the falling edge and queue what the following rising
    // edge must produce on the selected instance.
    task automatic step(input int sel, input bit e, input bit wv, input bit clr,
                        input bit eh, input int ec, input bit ez, input int el);
        exp_t x;
        @(negedge clk);
        en = e;
        w = wv;
        clr_cnt = clr;
        step_no++;
        x.sel = sel;
        x.idx = step_no;
        x.eh = eh;
        x.ec = ec;
        x.ez = ez;
        x.el = el;
        sb.push_back(x);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        en = 1'b0;
        w = 1'b0;
        clr_cnt = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Monitor: one queued expectation per sampled edge.
    always @(posedge clk) begin
        exp_t e;
        int h, c, zz, l;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                0: begin h = int'(hit4); c = int'(hc4); zz = int'(z4); l = int'(leds4); end
                1: begin h = int'(hitn); c = int'(hcn); zz = int'(zn); l = int'(ledsn); end
                default: begin h = int'(hitc); c = int'(hcc); zz = int'(zc); l = int'(ledsc); end
            endcase
            chk($sformatf("step%0d hit", e.idx), h, int'(e.eh));
            chk($sformatf("step%0d hit_count", e.idx), c, e.ec);
            chk($sformatf("step%0d z", e.idx), zz, int'(e.ez));
            chk($sformatf("step%0d leds", e.idx), l, e.el);
        end
    end

    initial begin
        do_reset();
        chk("reset z", int'(z4), 0);
        chk("reset hit_count", int'(hc4), 0);
        chk("reset leds", int'(leds4), 0);

        // Run of 1s with overlap, then reset mid-stream
        mode = 2'b00;
        step(0, 1, 1, 0, 0, 0, 0, 9);
        step(0, 1, 1, 0, 0, 0, 0, 10);
        step(0, 1, 1, 0, 0, 0, 0, 11);
        step(0, 1, 1, 0, 1, 1, 1, 12);
        step(0, 1, 1, 0, 1, 2, 1, 12);
        @(negedge clk);
        reset = 1'b0;
        en = 1'b0;
        #1;
        chk("async reset z", int'(z4), 0);
        chk("async reset hit", int'(hit4), 0);
        chk("async reset hit_count", int'(hc4), 0);
        chk("async reset leds", int'(leds4), 0);
        @(negedge clk);
        reset = 1'b1;
        step(0, 1, 1, 0, 0, 0, 0, 9);
        step(0, 1, 1, 0, 0, 0, 0, 10);
        step(0, 1, 1, 0, 0, 0, 0, 11);
        step(0, 1, 1, 0, 1, 1, 1, 12);

        // Overlap on zeros, en=0 hold, polarity flip after detection
        do_reset();
        step(0, 1, 0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0, 2);
        step(0, 1, 0, 0, 0, 0, 0, 3);
        step(0, 1, 0, 0, 1, 1, 1, 4);
        step(0, 1, 0, 0, 1, 2, 1, 4);
        step(0, 1, 0, 0, 1, 3, 1, 4);
        step(0, 0, 0, 0, 0, 3, 1, 4);
        step(0, 1, 1, 0, 0, 3, 0, 9);

        // Non-overlapping: eight 1s
        do_reset();
        step(1, 1, 1, 0, 0, 0, 0, 9);
        step(1, 1, 1, 0, 0, 0, 0, 10);
        step(1, 1, 1, 0, 0, 0, 0, 11);
        step(1, 1, 1, 0, 1, 1, 1, 12);
        step(1, 1, 1, 0, 0, 1, 0, 9);
        step(1, 1, 1, 0, 0, 1, 0, 10);
        step(1, 1, 1, 0, 0, 1, 0, 11);
        step(1, 1, 1, 0, 1, 2, 1, 12);

        // Polarity filter: ones only
        do_reset();
        mode = 2'b01;
        step(0, 1, 0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0, 2);
        step(0, 1, 0, 0, 0, 0, 0, 3);
        step(0, 1, 0, 0, 0, 0, 0, 4);
        step(0, 1, 1, 0, 0, 0, 0, 9);
        step(0, 1, 1, 0, 0, 0, 0, 10);
        step(0, 1, 1, 0, 0, 0, 0, 11);
        step(0, 1, 1, 0, 1, 1, 1, 12);
        @(negedge clk);
        en = 1'b0;
        chk("mode01 z before switch", int'(z4), 1);
        mode = 2'b10;
        #1;
        chk("mode10 z same cycle", int'(z4), 0);

        // en gaps keep the run alive
        do_reset();
        mode = 2'b00;
        step(0, 1, 1, 0, 0, 0, 0, 9);
        step(0, 1, 1, 0, 0, 0, 0, 10);
        step(0, 0, 0, 0, 0, 0, 0, 10);
        step(0, 0, 0, 0, 0, 0, 0, 10);
        step(0, 0, 0, 0, 0, 0, 0, 10);
        step(0, 1, 1, 0, 0, 0, 0, 11);
        step(0, 1, 1, 0, 1, 1, 1, 12);

        // A differing bit breaks the run
        do_reset();
        step(0, 1, 1, 0, 0, 0, 0, 9);
        step(0, 1, 1, 0, 0, 0, 0, 10);
        step(0, 1, 1, 0, 0, 0, 0, 11);
        step(0, 1, 0, 0, 0, 0, 0, 1);
        step(0, 1, 1, 0, 0, 0, 0, 9);
        step(0, 1, 1, 0, 0, 0, 0, 10);
        step(0, 1, 1, 0, 0, 0, 0, 11);

        // 2-bit counter saturates, clear wins over a detection
        do_reset();
        step(2, 1, 1, 0, 0, 0, 0, 9);
        step(2, 1, 1, 0, 0, 0, 0, 10);
        step(2, 1, 1, 0, 0, 0, 0, 11);
        step(2, 1, 1, 0, 1, 1, 1, 12);
        step(2, 1, 1, 0, 1, 2, 1, 12);
        step(2, 1, 1, 0, 1, 3, 1, 12);
        step(2, 1, 1, 0, 1, 3, 1, 12);
        step(2, 1, 1, 0, 1, 3, 1, 12);
        step(2, 1, 1, 1, 1, 0, 1, 12);
        step(2, 1, 1, 0, 1, 1, 1, 12);

        // Detection disabled: tracking continues, nothing counted
        do_reset();
        mode = 2'b11;
        step(0, 1, 1, 0, 0, 0, 0, 9);
        step(0, 1, 1, 0, 0, 0, 0, 10);
        step(0, 1, 1, 0, 0, 0, 0, 11);
        step(0, 1, 1, 0, 0, 0, 0, 12);
        step(0, 1, 1, 0, 0, 0, 0, 12);

        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("scoreboard drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
